// File: rtl/cy_motion_ctrl.sv
// Player movement, facing and attack controller producing sprite position and frame index.
// Optional macro CY_WRAP_EN makes the horizontal axis wrap instead of clamp.
`timescale 1ns/1ps
module cy_motion_ctrl #(
    parameter int SCREEN_H = 640,
    parameter int SCREEN_V = 480,
    parameter int SIZE     = 20,
    parameter int STEP     = 2,
    parameter int START_H  = 310,
    parameter int START_V  = 230,
    parameter int ANIM_DIV = 8,
    parameter int ATK_LEN  = 16,
    parameter int ATK_CD   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       W_signal,
    input  logic       A_signal,
    input  logic       S_signal,
    input  logic       D_signal,
    input  logic       J_signal,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v,
    output logic [1:0] dir,
    output logic [3:0] sprite_idx,
    output logic       attack_active,
    output logic       moving
);
    localparam int MAX_H = SCREEN_H - SIZE;
    localparam int MAX_V = SCREEN_V - SIZE;
    localparam int TW    = $clog2((ATK_LEN > ATK_CD) ? ATK_LEN : ATK_CD);
    localparam int AW    = $clog2(ANIM_DIV);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] MAX_H_S = 11'(MAX_H);
    localparam logic signed [10:0] MAX_V_S = 11'(MAX_V);

    localparam logic [1:0] DIR_FRONT = 2'd0;
    localparam logic [1:0] DIR_BACK  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ATTACK   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [AW-1:0] anim_cnt, anim_cnt_n;
    logic          phase, phase_n;
    logic          j_prev;
    logic [9:0]    pos_h_n, pos_v_n;
    logic [1:0]    dir_n;
    logic [3:0]    sprite_n;
    logic          moving_n;

    logic                go_left, go_right, go_up, go_down, j_edge, frozen;
    logic signed [10:0]  h_try, v_try;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            anim_cnt   <= '0;
            phase      <= 1'b0;
            j_prev     <= 1'b0;
            pos_h      <= 10'(START_H);
            pos_v      <= 10'(START_V);
            dir        <= DIR_FRONT;
            sprite_idx <= 4'd1;
            moving     <= 1'b0;
        end else if (tick) begin
            state      <= state_n;
            timer      <= timer_n;
            anim_cnt   <= anim_cnt_n;
            phase      <= phase_n;
            j_prev     <= J_signal;
            pos_h      <= pos_h_n;
            pos_v      <= pos_v_n;
            dir        <= dir_n;
            sprite_idx <= sprite_n;
            moving     <= moving_n;
        end
    end

    assign attack_active = (state == ATTACK);

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        anim_cnt_n = anim_cnt;
        phase_n    = phase;
        pos_h_n    = pos_h;
        pos_v_n    = pos_v;
        dir_n      = dir;
        sprite_n   = sprite_idx;
        moving_n   = 1'b0;

        go_left  = A_signal & ~D_signal;
        go_right = D_signal & ~A_signal;
        go_up    = W_signal & ~S_signal;
        go_down  = S_signal & ~W_signal;
        j_edge   = J_signal & ~j_prev;
        // The tick that starts an attack is already frozen.
        frozen   = (state == ATTACK) || ((state == IDLE) && j_edge);

        case (state)
            IDLE: begin
                if (j_edge) begin
                    state_n = ATTACK;
                    timer_n = '0;
                end
            end
            ATTACK: begin
                if (timer == TW'(ATK_LEN - 1)) begin
                    state_n = COOLDOWN;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            COOLDOWN: begin
                if (timer == TW'(ATK_CD - 1)) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        h_try = $signed({1'b0, pos_h});
        if (go_left)  h_try = h_try - STEP_S;
        if (go_right) h_try = h_try + STEP_S;
        v_try = $signed({1'b0, pos_v});
        if (go_up)    v_try = v_try - STEP_S;
        if (go_down)  v_try = v_try + STEP_S;

        if (!frozen) begin
`ifdef CY_WRAP_EN
            if (h_try < 11'sd0)        pos_h_n = 10'(MAX_H);
            else if (h_try > MAX_H_S)  pos_h_n = 10'd0;
            else                       pos_h_n = h_try[9:0];
`else
            if (h_try < 11'sd0)        pos_h_n = 10'd0;
            else if (h_try > MAX_H_S)  pos_h_n = 10'(MAX_H);
            else                       pos_h_n = h_try[9:0];
`endif
            if (v_try < 11'sd0)        pos_v_n = 10'd0;
            else if (v_try > MAX_V_S)  pos_v_n = 10'(MAX_V);
            else                       pos_v_n = v_try[9:0];

            if (go_up)         dir_n = DIR_BACK;
            else if (go_down)  dir_n = DIR_FRONT;
            else if (go_left)  dir_n = DIR_LEFT;
            else if (go_right) dir_n = DIR_RIGHT;
        end

        moving_n = (pos_h_n != pos_h) || (pos_v_n != pos_v);

        if (moving_n) begin
            if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                anim_cnt_n = '0;
                phase_n    = ~phase;
            end else begin
                anim_cnt_n = anim_cnt + 1'b1;
            end
        end else begin
            anim_cnt_n = '0;
            phase_n    = 1'b0;
        end

        // Frame for the state this tick produces; attack pose overrides walking.
        if (state_n == ATTACK) begin
            sprite_n = 4'd11 + {2'b00, dir_n};
        end else begin
            case (dir_n)
                DIR_FRONT: sprite_n = !moving_n ? 4'd1 : (phase_n ? 4'd3 : 4'd2);
                DIR_BACK:  sprite_n = !moving_n ? 4'd4 : (phase_n ? 4'd6 : 4'd5);
                DIR_LEFT:  sprite_n = (moving_n && !phase_n) ? 4'd8 : 4'd7;
                default:   sprite_n = (moving_n && !phase_n) ? 4'd10 : 4'd9;
            endcase
        end
    end
endmodule

// File: tb/tb_cy_motion_ctrl.sv
// Directed self-checking bench for cy_motion_ctrl (default clamp build or CY_WRAP_EN build).
`timescale 1ns/1ps
module tb_cy_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       w_key, a_key, s_key, d_key, j_key;
    logic [9:0] pos_h, pos_v;
    logic [1:0] dir;
    logic [3:0] sprite_idx;
    logic       attack_active, moving;

    int n_cmp = 0;
    int n_err = 0;

    cy_motion_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .W_signal      (w_key),
        .A_signal      (a_key),
        .S_signal      (s_key),
        .D_signal      (d_key),
        .J_signal      (j_key),
        .pos_h         (pos_h),
        .pos_v         (pos_v),
        .dir           (dir),
        .sprite_idx    (sprite_idx),
        .attack_active (attack_active),
        .moving        (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic keys(input logic w, input logic a, input logic s, input logic d, input logic j);
        w_key = w; a_key = a; s_key = s; d_key = d; j_key = j;
    endtask

    // Advance n rising edges, then settle 1ns so outputs are sampled away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b1;
        keys(0, 0, 0, 0, 0);
        #2;
        check("reset_pos_h", pos_h, 310);
        check("reset_pos_v", pos_v, 230);
        check("reset_dir", dir, 0);
        check("reset_sprite", sprite_idx, 1);
        check("reset_attack", attack_active, 0);
        check("reset_moving", moving, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Walk right: walk frame for 7 ticks, stand frame on the 8th (phase toggle).
        keys(0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("d_walk_sprite", sprite_idx, 10);
        end
        check("d5_pos_h", pos_h, 320);
        check("d5_dir", dir, 3);
        check("d5_moving", moving, 1);
        step(2);
        check("d7_sprite", sprite_idx, 10);
        step(1);
        check("d8_sprite_phase1", sprite_idx, 9);
        check("d8_pos_h", pos_h, 326);
        keys(0, 0, 0, 0, 0);
        step(1);
        check("d_release_sprite", sprite_idx, 9);
        check("d_release_moving", moving, 0);
        check("d_release_pos_h", pos_h, 326);

        // tick low freezes everything even with a key held.
        tick = 1'b0;
        keys(0, 0, 0, 1, 0);
        step(3);
        check("notick_pos_h", pos_h, 326);
        check("notick_moving", moving, 0);
        tick = 1'b1;

        // Travel to (100,50), then assert reset mid-cycle.
        keys(1, 1, 0, 0, 0);
        step(90);
        keys(0, 1, 0, 0, 0);
        step(23);
        check("pre_rst_pos_h", pos_h, 100);
        check("pre_rst_pos_v", pos_v, 50);
        check("pre_rst_dir", dir, 2);
        keys(0, 0, 0, 0, 0);
        pulse_reset();
        check("mid_rst_pos_h", pos_h, 310);
        check("mid_rst_pos_v", pos_v, 230);
        check("mid_rst_dir", dir, 0);
        check("mid_rst_sprite", sprite_idx, 1);
        check("mid_rst_attack", attack_active, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Diagonal into the top-left corner with saturation.
        keys(1, 1, 0, 0, 0);
        step(114);
        keys(0, 1, 0, 0, 0);
        step(40);
        check("corner_pre_h", pos_h, 2);
        check("corner_pre_v", pos_v, 2);
        keys(1, 1, 0, 0, 0);
        step(1);
        check("corner_h", pos_h, 0);
        check("corner_v", pos_v, 0);
        check("corner_dir", dir, 1);
        check("corner_moving", moving, 1);
        step(1);
        check("wall_v", pos_v, 0);
`ifdef CY_WRAP_EN
        check("wall_h_wrap", pos_h, 620);
        check("wall_moving_wrap", moving, 1);
`else
        check("wall_h", pos_h, 0);
        check("wall_moving", moving, 0);
        check("wall_sprite", sprite_idx, 4);
`endif
        keys(0, 0, 0, 0, 0);
        step(1);
        check("idle_moving", moving, 0);

        // A+D cancel, S moves down; front walk alternates 2/3 every 8 ticks.
        keys(0, 1, 1, 1, 0);
        step(1);
        check("s1_sprite", sprite_idx, 2);
        check("s1_pos_v", pos_v, 2);
        check("s1_dir", dir, 0);
        step(6);
        check("s7_sprite", sprite_idx, 2);
        step(1);
        check("s8_sprite", sprite_idx, 3);
        step(7);
        check("s15_sprite", sprite_idx, 3);
        step(1);
        check("s16_sprite", sprite_idx, 2);
        check("s16_pos_v", pos_v, 32);
`ifdef CY_WRAP_EN
        check("s16_pos_h", pos_h, 620);
`else
        check("s16_pos_h", pos_h, 0);
`endif

        // Attack facing left while A is held.
        keys(0, 0, 0, 0, 0);
        pulse_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        keys(0, 0, 0, 1, 0);
        step(1);
        keys(0, 1, 0, 0, 0);
        step(1);
        check("pre_atk_pos_h", pos_h, 310);
        check("pre_atk_dir", dir, 2);
        keys(0, 1, 0, 0, 1);
        step(1);
        check("atk_t0_active", attack_active, 1);
        check("atk_t0_sprite", sprite_idx, 13);
        check("atk_t0_pos_h", pos_h, 310);
        check("atk_t0_moving", moving, 0);
        for (int t = 1; t <= 15; t++) begin
            step(1);
            check("atk_hold_active", attack_active, 1);
            check("atk_hold_pos_h", pos_h, 310);
        end
        check("atk_t15_sprite", sprite_idx, 13);
        check("atk_t15_dir", dir, 2);
        step(1);
        check("atk_t16_active", attack_active, 0);
        check("atk_t16_pos_h", pos_h, 310);
        check("atk_t16_sprite", sprite_idx, 7);
        step(1);
        check("cd1_pos_h", pos_h, 308);
        check("cd1_moving", moving, 1);
        keys(0, 1, 0, 0, 0);
        step(8);
        keys(0, 1, 0, 0, 1);
        step(1);
        check("cd10_repress_active", attack_active, 0);
        step(22);
        check("cd_end_active", attack_active, 0);
        check("cd_end_pos_h", pos_h, 246);
        step(1);
        check("held_j_active", attack_active, 0);
        check("held_j_pos_h", pos_h, 244);
        keys(0, 1, 0, 0, 0);
        step(1);
        keys(0, 1, 0, 0, 1);
        step(1);
        check("retrig_active", attack_active, 1);
        check("retrig_sprite", sprite_idx, 13);
        check("retrig_pos_h", pos_h, 242);
        step(3);
        keys(0, 0, 0, 0, 0);
        pulse_reset();
        check("atk_rst_active", attack_active, 0);
        check("atk_rst_pos_h", pos_h, 310);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        check("post_rst_active", attack_active, 0);
        check("post_rst_sprite", sprite_idx, 1);

        // Right wall: clamp by default, wrap to 0 with CY_WRAP_EN.
        keys(0, 0, 0, 1, 0);
        step(155);
        check("right_edge_h", pos_h, 620);
        check("right_edge_moving", moving, 1);
        step(1);
`ifdef CY_WRAP_EN
        check("right_wrap_h", pos_h, 0);
        check("right_wrap_moving", moving, 1);
        keys(0, 1, 0, 0, 0);
        step(1);
        check("left_wrap_h", pos_h, 620);
        check("left_wrap_moving", moving, 1);
`else
        check("right_clamp_h", pos_h, 620);
        check("right_clamp_moving", moving, 0);
        keys(0, 1, 0, 0, 0);
        step(1);
        check("left_from_edge_h", pos_h, 618);
        check("left_from_edge_moving", moving, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cy_motion_ctrl.md
Name: cy_motion_ctrl

Overview:
- Player (CY) movement and animation controller, one stage upstream of the sprite select/address path.
- Consumes keyboard key_down levels (W/A/S/D/J); produces the CY top-left screen position for the sprite address generator and the select_pixel instance.
- Also produces the sprite frame index that drives now_pixel_idx, plus facing direction and attack status for the game state logic.
- Clocked by the slow state-control clock (clk_d22); `tick` thins updates further.

Parameters:
SCREEN_H, 640, visible width in pixels
SCREEN_V, 480, visible height in pixels
SIZE, 20, sprite edge in pixels (square)
STEP, 2, pixels moved per axis per tick
START_H, 310, reset pos_h
START_V, 230, reset pos_v
ANIM_DIV, 8, moving ticks per walk-phase toggle
ATK_LEN, 16, ticks spent in ATTACK
ATK_CD, 32, ticks spent in COOLDOWN

Ports:
clk  in  1  state clock (clk_d22 in top)
rst  in  1  asynchronous, active-high reset
tick  in  1  update enable; tie 1 for every-cycle update
W_signal  in  1  up key level
A_signal  in  1  left key level
S_signal  in  1  down key level
D_signal  in  1  right key level
J_signal  in  1  attack key level
pos_h  out  10  sprite left x
pos_v  out  10  sprite top y
dir  out  2  facing: 0 front/down, 1 back/up, 2 left, 3 right
sprite_idx  out  4  frame index for select_pixel
attack_active  out  1  high while FSM is in ATTACK
moving  out  1  high while position changed on last tick

Behaviour:
- Reset (async, immediate):
  - pos_h=START_H, pos_v=START_V, dir=0, sprite_idx=1, attack_active=0, moving=0.
  - FSM=IDLE; anim counter=0; phase=0; J edge register=0.
- All outputs registered. Updates occur only on rising clk with tick=1; outputs reflect the tick one cycle later. With tick=0 all state holds.
- Axis intent:
  - Horizontal: -1 if A&!D, +1 if D&!A, else 0.
  - Vertical: -1 if W&!S, +1 if S&!W, else 0.
  - Opposing keys cancel on that axis only. Diagonal motion is allowed; each axis moves STEP.
- Bounds (clamp, no wrap):
  - pos_h range 0..SCREEN_H-SIZE (620); pos_v range 0..SCREEN_V-SIZE (460).
  - Subtraction uses an 11-bit signed intermediate; a result below 0 saturates to 0, a result above the max saturates to the max.
- moving=1 iff pos_h or pos_v actually changed this tick. Pushing against a wall gives moving=0.
- dir updates only when some axis intent is nonzero. Priority: W > S > A > D, after cancellation.
- Walk animation:
  - While moving=1, the anim counter increments; at ANIM_DIV-1 it wraps to 0 and toggles phase.
  - When moving=0, counter=0 and phase=0.
- Attack FSM:
  - IDLE -> ATTACK on J rising edge (J & !J_prev, sampled on ticks).
  - ATTACK holds ATK_LEN ticks, then -> COOLDOWN.
  - COOLDOWN holds ATK_CD ticks, then -> IDLE.
  - J edges in ATTACK or COOLDOWN are ignored; they are not queued.
  - Holding J does not retrigger; release and re-press are required.
- In ATTACK, position is frozen (moving=0) and dir is frozen. In COOLDOWN, movement is allowed.
- sprite_idx map:
  - Front: stand=1, walk_L=2, walk_R=3.
  - Back: stand=4, walk_L=5, walk_R=6.
  - Left: stand=7, walk=8.
  - Right: stand=9, walk=10.
  - Attack: front=11, back=12, left=13, right=14.
  - Moving front/back: phase0 -> walk_L, phase1 -> walk_R.
  - Moving left/right: phase0 -> walk, phase1 -> stand.
  - Not moving: stand.
  - ATTACK overrides by dir.
- Simultaneous J edge and movement keys on the same tick: the attack wins, and position is not updated that tick.
- Reset mid-attack returns the FSM to IDLE; the cooldown is not preserved.

Optional Feature:
CY_WRAP_EN
- Defined: the horizontal axis wraps instead of clamping.
  - Moving left from pos_h<STEP gives pos_h = SCREEN_H-SIZE.
  - Moving right past SCREEN_H-SIZE gives pos_h = 0.
  - A wrap counts as moving=1.
  - The vertical axis still clamps.
- Undefined: both axes clamp as above.

Test Plan:
- Reset asserted mid-run with pos=(100,50) -> same cycle: pos=(310,230), dir=0, sprite_idx=1, attack_active=0.
- D held 5 ticks from reset -> pos_h=320, dir=3, moving=1. sprite_idx sequence 10,10,10,10,10; after 8 ticks phase toggles and sprite_idx=9. Release -> sprite_idx=9, moving=0.
- W+A held from pos=(2,1) -> next tick pos=(0,0), dir=1. Following tick pos stays (0,0), moving=0, sprite_idx=4.
- A+D held with S -> pos_h unchanged, pos_v +2 per tick, dir=0, sprite_idx alternates 2/3 every 8 ticks.
- J pressed facing left while A held -> attack_active=1 for 16 ticks, sprite_idx=13, pos frozen. Then 32 cooldown ticks with movement resumed. A J re-press at cooldown tick 10 is ignored; a re-press after cooldown retriggers.
- With CY_WRAP_EN, pos_h=1, A held one tick -> pos_h=620, moving=1. Without the macro -> pos_h=0.
